// File: rtl/dbuf_burst_if.sv
// Burst buffer bus: command channel, write-beat channel and read/status returns.
//   cmd_valid/cmd_ready  command handshake; cmd_rw 1=write, 0=read
//   cmd_addr, cmd_len    start address and beats-minus-one
//   wr_data/wr_valid     write beats, accepted while wr_ready is high
//   rd_data/rd_valid     registered read beats, no backpressure; rd_last marks final beat
//   busy, done, err      FSM activity, end-of-command pulse, bad-address pulse
// master: command source (testbench / upstream). slave: the buffer.
interface dbuf_burst_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 16
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_rw;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_last;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_data, wr_valid,
    input  cmd_ready, wr_ready, rd_data, rd_valid, rd_last, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_data, wr_valid,
    output cmd_ready, wr_ready, rd_data, rd_valid, rd_last, busy, done, err
  );
endinterface

// File: rtl/dbuf_burst.sv
// Burst-addressed single-port data buffer: DEPTH words of DW bits.
// A command supplies a start address and a beat count (cmd_len = beats-1); addresses
// auto-increment and wrap from DEPTH-1 to 0. Writes take one beat per wr_valid while
// wr_ready is high; reads stream one registered word per cycle. Every accepted command
// ends with a one-cycle done pulse; an out-of-range start address skips the RAM and
// raises err together with done.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (RAM contents are kept)
//   bus  dbuf_burst_if slave modport (command, write beats, read beats, status)
module dbuf_burst #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 16,
  parameter int unsigned DEPTH = 1024
) (
  input logic         clk,
  input logic         rst,
  dbuf_burst_if.slave bus
);

  localparam int unsigned     IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2^AW still compares correctly.
  localparam logic [AW:0]     DepthExt = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0]   LastAddr = AW'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] cnt_q;
  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] addr_inc;
  logic [IdxW-1:0] mem_idx;
  logic          wr_fire;

  assign addr_inc = (addr_q == LastAddr) ? '0 : addr_q + AW'(1);
  // addr_q is always < DEPTH while in WRITE or READ, so the low bits index the RAM.
  assign mem_idx  = addr_q[IdxW-1:0];
  assign wr_fire  = (state_q == StWrite) && bus.wr_valid;

  // RAM has no reset; a reset edge only blocks the write in that cycle.
  always_ff @(posedge clk) begin
    if (!rst && wr_fire) begin
      mem[mem_idx] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      cnt_q         <= '0;
      bus.cmd_ready <= 1'b1;
      bus.wr_ready  <= 1'b0;
      bus.rd_data   <= '0;
      bus.rd_valid  <= 1'b0;
      bus.rd_last   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      // Pulse outputs default low each cycle.
      bus.rd_valid <= 1'b0;
      bus.rd_last  <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            addr_q        <= bus.cmd_addr;
            cnt_q         <= bus.cmd_len;
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b1;
            if ({1'b0, bus.cmd_addr} >= DepthExt) begin
              state_q  <= StDone;
              bus.done <= 1'b1;
              bus.err  <= 1'b1;
            end else if (bus.cmd_rw) begin
              state_q      <= StWrite;
              bus.wr_ready <= 1'b1;
            end else begin
              state_q <= StRead;
            end
          end
        end

        StWrite: begin
          if (bus.wr_valid) begin
            addr_q <= addr_inc;
            cnt_q  <= cnt_q - AW'(1);
            if (cnt_q == '0) begin
              state_q      <= StDone;
              bus.done     <= 1'b1;
              bus.wr_ready <= 1'b0;
            end
          end
        end

        StRead: begin
          bus.rd_data  <= mem[mem_idx];
          bus.rd_valid <= 1'b1;
          addr_q       <= addr_inc;
          cnt_q        <= cnt_q - AW'(1);
          // The last beat lands in the same cycle as the done pulse.
          if (cnt_q == '0) begin
            state_q     <= StDone;
            bus.rd_last <= 1'b1;
            bus.done    <= 1'b1;
          end
        end

        StDone: begin
          state_q       <= StIdle;
          bus.cmd_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbuf_burst.sv
// Scoreboard bench for dbuf_burst. The driver issues commands and keeps a plain array
// model of the RAM; on each command it queues the expected read beats and done/err
// outcome. An independent monitor pops and compares whenever rd_valid or done appears.
module tb_dbuf_burst;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 16;
  localparam int unsigned DEPTH = 1024;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dbuf_burst_if #(.DW(DW), .AW(AW)) bus ();

  dbuf_burst #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rd_exp_t       exp_rd[$];
  bit            exp_done[$];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] fixed_data[$];
  int            checks = 0;
  int            errors = 0;

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endfunction

  // Monitor: consumes expectations whenever the DUT presents a read beat or done.
  always @(negedge clk) begin
    rd_exp_t e;
    bit      e_err;
    if (bus.rd_valid === 1'b1) begin
      if (exp_rd.size() == 0) begin
        check("rd_unexpected", 1, 0);
      end else begin
        e = exp_rd.pop_front();
        check("rd_data", bus.rd_data, e.data);
        check("rd_last", bus.rd_last, e.last);
        check("rd_last_with_done", bus.done, e.last);
      end
    end
    if (bus.done === 1'b1) begin
      if (exp_done.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        e_err = exp_done.pop_front();
        check("err_flag", bus.err, e_err);
      end
    end else if (bus.err === 1'b1) begin
      check("err_without_done", 1, 0);
    end
  end

  // stall_mode: 0 continuous, 1 random gaps, 2 five idle cycles between beats.
  // rst_beat >= 0 asserts reset while that write beat is presented.
  task automatic run_cmd(input bit rw, input int addr, input int len, input int stall_mode,
                         input int rst_beat, output int ready_cycles);
    int            bound;
    int            a;
    int            beat;
    int            gap;
    bit            stall;
    bit            busy_ok;
    bit            ok;
    logic [DW-1:0] d;
    ready_cycles = 0;
    d = '0;
    @(negedge clk);
    bound = 0;
    while (bus.cmd_ready !== 1'b1) begin
      bound++;
      if (bound > 50) begin
        check("cmd_ready_wait", 0, 1);
        return;
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = rw;
    bus.cmd_addr  = AW'(addr);
    bus.cmd_len   = AW'(len);
    if (addr >= int'(DEPTH)) begin
      exp_done.push_back(1'b1);
    end else begin
      exp_done.push_back(1'b0);
      if (!rw) begin
        for (int i = 0; i <= len; i++) begin
          exp_rd.push_back('{data: ref_mem[(addr + i) % DEPTH], last: (i == len)});
        end
      end
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = AW'($urandom);
    bus.cmd_len   = AW'($urandom);

    if (addr >= int'(DEPTH)) begin
      check("err_done_latency", bus.done, 1);
      check("err_no_wr_ready", bus.wr_ready, 0);
      // Junk beat offered while no write is active must be ignored.
      bus.wr_valid = rw;
      bus.wr_data  = $urandom;
      @(negedge clk);
      bus.wr_valid = 1'b0;
      check("err_back_idle", bus.cmd_ready, 1);
    end else if (rw) begin
      a       = addr;
      beat    = 0;
      gap     = 0;
      bound   = 0;
      busy_ok = 1'b1;
      while (beat <= len) begin
        stall = 1'b0;
        if (gap > 0) begin
          stall = 1'b1;
          gap--;
        end else if (stall_mode == 1 && $urandom_range(0, 3) == 0) begin
          stall = 1'b1;
        end
        if (stall) begin
          bus.wr_valid = 1'b0;
          bus.wr_data  = $urandom;
        end else begin
          d = (fixed_data.size() > 0) ? fixed_data[0] : $urandom;
          bus.wr_valid = 1'b1;
          bus.wr_data  = d;
        end
        if (!stall && beat == rst_beat) begin
          rst = 1'b1;
          exp_done.delete();
          exp_rd.delete();
          @(negedge clk);
          check("rst_cmd_ready", bus.cmd_ready, 1);
          check("rst_busy", bus.busy, 0);
          check("rst_wr_ready", bus.wr_ready, 0);
          check("rst_no_done", bus.done, 0);
          rst          = 1'b0;
          bus.wr_valid = 1'b0;
          return;
        end
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
        if (bus.wr_ready === 1'b1) ready_cycles++;
        if (bus.wr_valid && bus.wr_ready === 1'b1) begin
          ref_mem[a] = d;
          if (fixed_data.size() > 0) void'(fixed_data.pop_front());
          a = (a + 1) % DEPTH;
          beat++;
          if (stall_mode == 2) gap = 5;
        end
        @(negedge clk);
        bound++;
        if (bound > 20 * (len + 1) + 50) begin
          check("wr_burst_timeout", 0, 1);
          bus.wr_valid = 1'b0;
          return;
        end
      end
      bus.wr_valid = 1'b0;
      check("wr_done_latency", bus.done, 1);
      check("wr_ready_drop", bus.wr_ready, 0);
      check("wr_busy_during_burst", busy_ok, 1);
      @(negedge clk);
    end else begin
      check("rd_first_gap", bus.rd_valid, 0);
      ok = 1'b1;
      for (int i = 0; i <= len; i++) begin
        // Write beats offered during a read must be ignored.
        bus.wr_valid = 1'($urandom_range(0, 1));
        bus.wr_data  = $urandom;
        @(negedge clk);
        if (bus.rd_valid !== 1'b1) ok = 1'b0;
      end
      bus.wr_valid = 1'b0;
      check("rd_stream_contiguous", ok, 1);
      @(negedge clk);
    end
    check("cmd_drained", exp_done.size() + exp_rd.size(), 0);
    check("idle_after_cmd", bus.busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    int addr;
    bus.cmd_valid = 1'b0;
    bus.cmd_rw    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_cmd_ready", bus.cmd_ready, 1);
    check("reset_wr_ready", bus.wr_ready, 0);
    check("reset_rd_valid", bus.rd_valid, 0);
    check("reset_rd_last", bus.rd_last, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_err", bus.err, 0);
    check("reset_rd_data", bus.rd_data, 0);
    rst = 1'b0;

    // Fill the whole RAM so the model is fully defined.
    run_cmd(1'b1, 0, DEPTH - 1, 0, -1, rc);

    fixed_data = '{32'h11, 32'h22, 32'h33, 32'h44};
    run_cmd(1'b1, 0, 3, 0, -1, rc);
    check("wr_ready_cycles", rc, 4);
    run_cmd(1'b0, 0, 3, 0, -1, rc);

    // Wrapping burst across DEPTH-1 -> 0.
    fixed_data = '{32'hA, 32'hB, 32'hC, 32'hD};
    run_cmd(1'b1, DEPTH - 2, 3, 0, -1, rc);
    run_cmd(1'b0, DEPTH - 2, 3, 0, -1, rc);
    run_cmd(1'b0, 0, 2, 0, -1, rc);

    // Stalled write: five idle cycles between beats.
    run_cmd(1'b1, 100, 2, 2, -1, rc);
    run_cmd(1'b0, 99, 4, 0, -1, rc);

    // Out-of-range start addresses.
    run_cmd(1'b0, DEPTH, 3, 0, -1, rc);
    run_cmd(1'b1, DEPTH, 3, 0, -1, rc);
    run_cmd(1'b1, 65535, 0, 0, -1, rc);
    run_cmd(1'b0, 0, 7, 0, -1, rc);
    run_cmd(1'b0, DEPTH - 4, 7, 0, -1, rc);

    // Reset during beat 2 of an 8-beat write.
    run_cmd(1'b1, 200, 7, 0, 2, rc);
    run_cmd(1'b0, 198, 11, 0, -1, rc);

    // Long read wrapping the buffer twice.
    run_cmd(1'b0, 5, 2100, 0, -1, rc);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 11) == 0) addr = DEPTH + $urandom_range(0, 100);
      else addr = $urandom_range(0, DEPTH - 1);
      run_cmd(1'($urandom_range(0, 1)), addr, $urandom_range(0, 40), $urandom_range(0, 1),
              -1, rc);
    end

    run_cmd(1'b0, 0, DEPTH - 1, 0, -1, rc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbuf_burst.md
Name: dbuf_burst

Overview:
- Parametrised successor to the single-port data buffer.
- Single-clock synchronous RAM of DEPTH words × DW bits.
- Accessed by burst commands: start address plus beat count, with auto-incrementing, wrapping addresses.
- Writes use a valid/ready beat handshake; reads stream one word per cycle, with a last-beat flag and a done/error indication per command.

Parameters:
- DW, 32, data word width in bits.
- AW, 16, address and length field width.
- DEPTH, 1024, number of words; legal addresses are 0..DEPTH-1; DEPTH ≤ 2^AW.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_rw  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  AW  burst start address.
- cmd_len  in  AW  beats minus one (0 → 1 beat).
- wr_data  in  DW  write beat data.
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  buffer accepts write beat.
- rd_data  out  DW  read beat data (registered).
- rd_valid  out  1  rd_data valid this cycle; no backpressure.
- rd_last  out  1  final beat of read burst, qualified by rd_valid.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  one-cycle pulse at end of every accepted command.
- err  out  1  one-cycle pulse with done when cmd_addr ≥ DEPTH.

Behaviour:
- Reset (rst high at clock edge):
  - FSM → IDLE.
  - cmd_ready=1; wr_ready=0, rd_valid=0, rd_last=0, busy=0, done=0, err=0; rd_data=0.
  - RAM contents are not cleared.
  - Reset mid-burst aborts the burst; words already written stay in RAM.
- States: IDLE, WRITE, READ, DONE.
- IDLE:
  - cmd_ready=1.
  - On accept, latch addr=cmd_addr and cnt=cmd_len.
  - cmd_addr ≥ DEPTH → DONE with err flagged; no RAM access.
  - Otherwise cmd_rw=1 → WRITE, cmd_rw=0 → READ.
- WRITE:
  - wr_ready=1.
  - Each wr_valid beat writes mem[addr]<=wr_data, then addr increments and cnt decrements.
  - wr_valid low stalls the burst indefinitely with no timeout.
  - Beat accepted with cnt==0 → DONE.
- READ:
  - Every cycle read mem[addr] into rd_data; rd_valid=1 the following cycle.
  - addr increments and cnt decrements each cycle.
  - Beat issued with cnt==0 → DONE.
- DONE:
  - Held one cycle: done=1, err as latched, cmd_ready=0.
  - For reads, DONE is also the cycle carrying the last rd_valid with rd_last=1.
  - Then → IDLE.
- Address wrap: addr==DEPTH-1 increments to 0, for both writes and reads.
- cmd_ready is 0 in WRITE, READ and DONE. cmd_valid there is ignored and must be held by the source.
- Latency:
  - Read command accepted at cycle t → first rd_valid at t+2, last at t+N+1, done at t+N+1 (N = cmd_len+1).
  - Write done is one cycle after the last accepted beat.
- Data written by one burst is readable by any later command (no same-cycle read/write path exists).
- Width rules:
  - cnt and addr are AW bits.
  - cmd_len up to 2^AW-1 beats is legal, wrapping the buffer repeatedly.
- wr_ready is 0 outside WRITE; wr_valid outside WRITE is ignored.

Test Plan:
- Reset, then write burst addr=0, len=3, data 0x11,0x22,0x33,0x44 with continuous wr_valid → wr_ready high 4 cycles, done pulse 1 cycle after 4th beat, err=0.
- Read burst addr=0, len=3 after above → rd_valid at t+2..t+5 with 0x11,0x22,0x33,0x44; rd_last and done both high only at t+5.
- Write burst addr=DEPTH-2 (1022), len=3, data A,B,C,D, then read addr=1022, len=3 → data A,B,C,D; words land at 1022,1023,0,1 (wrap).
- Write burst len=2 with wr_valid deasserted for 5 cycles between beats → exactly 3 words written, busy high throughout, done once.
- Command with cmd_addr=1024 → accepted, done=1 and err=1 the following cycle; no rd_valid; RAM unchanged (verified by re-read).
- Assert rst during beat 2 of a len=7 write → next cycle IDLE, cmd_ready=1, no done. Reading back shows beats 0–1 written and later addresses unchanged.
